// File: rtl/wbuf_pkg.sv
// Shared types and elaboration helpers for the K x K sliding-window buffer.
// Optional feature macro: WINDOW_BUFFER_BORDER_ZERO_EN.
package wbuf_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      FILL = 2'd1,
      RUN  = 2'd2
   } wbuf_state_e;

   // Counter width for a dimension of n positions; never narrower than one bit.
   function automatic int unsigned cnt_w(input int unsigned n);
      return (n < 2) ? 1 : $clog2(n);
   endfunction

   function automatic int unsigned row_cnt_w(input int unsigned rows);
      return cnt_w(rows);
   endfunction

   function automatic int unsigned col_cnt_w(input int unsigned cols);
      return cnt_w(cols);
   endfunction

   function automatic bit k_legal(input int unsigned k);
      return (k >= 3) && (k <= 9) && ((k % 2) == 1);
   endfunction

endpackage

// File: rtl/window_buffer_nxn_ctrl.sv
// Frame controller: row/column position, FILL/RUN sequencing, valid/done/busy flags.
// WINDOW_BUFFER_BORDER_ZERO_EN exports the pixel position and marks every pixel valid.
module window_buffer_nxn_ctrl
   import wbuf_pkg::*;
#(
   parameter int unsigned K    = 5,
   parameter int unsigned COLS = 7,
   parameter int unsigned ROWS = 7
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        clr_i,
   input  logic                        valid_i,
`ifdef WINDOW_BUFFER_BORDER_ZERO_EN
   output logic [row_cnt_w(ROWS)-1:0]  row_o,
   output logic [col_cnt_w(COLS)-1:0]  col_o,
`endif
   output logic                        valid_o,
   output logic                        frame_done_o,
   output logic                        busy_o
);

   localparam int unsigned RW = row_cnt_w(ROWS);
   localparam int unsigned CW = col_cnt_w(COLS);

   wbuf_state_e   state;
   logic [RW-1:0] row;
   logic [CW-1:0] col;
   logic          accept;
   logic          last_col;
   logic          last_row;
   logic          win_ok;

   assign accept   = valid_i & ~clr_i;
   assign last_col = (col == CW'(COLS - 1));
   assign last_row = (row == RW'(ROWS - 1));

`ifdef WINDOW_BUFFER_BORDER_ZERO_EN
   assign win_ok = 1'b1;
   assign row_o  = row;
   assign col_o  = col;
`else
   // Only windows fully inside the image, anchored at their lower-right pixel.
   assign win_ok = (row >= RW'(K - 1)) && (col >= CW'(K - 1));
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state        <= IDLE;
         row          <= '0;
         col          <= '0;
         valid_o      <= 1'b0;
         frame_done_o <= 1'b0;
         busy_o       <= 1'b0;
      end else if (clr_i) begin
         state        <= IDLE;
         row          <= '0;
         col          <= '0;
         valid_o      <= 1'b0;
         frame_done_o <= 1'b0;
         busy_o       <= 1'b0;
      end else begin
         valid_o      <= accept & win_ok;
         frame_done_o <= accept & last_col & last_row;
         if (accept) begin
            col <= last_col ? '0 : col + CW'(1);
            if (last_col) begin
               row <= last_row ? '0 : row + RW'(1);
            end
            unique case (state)
               IDLE: begin
                  state  <= FILL;
                  busy_o <= 1'b1;
               end
               FILL: begin
                  if (last_col && (row == RW'(K - 2))) begin
                     state <= RUN;
                  end
               end
               RUN: begin
                  if (last_col && last_row) begin
                     state  <= IDLE;
                     busy_o <= 1'b0;
                  end
               end
               default: begin
                  state  <= IDLE;
                  busy_o <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule

// File: rtl/window_buffer_nxn.sv
// K x K sliding-window tap array fed one vertical column per accepted pixel.
// WINDOW_BUFFER_BORDER_ZERO_EN: emit a window per pixel with out-of-image taps zeroed.
module window_buffer_nxn
   import wbuf_pkg::*;
#(
   parameter int unsigned K    = 5,
   parameter int unsigned DW   = 8,
   parameter int unsigned COLS = 7,
   parameter int unsigned ROWS = 7
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              clr_i,
   input  logic              valid_i,
   input  logic [K*DW-1:0]   col_i,
   output logic [K*K*DW-1:0] window_o,
   output logic              valid_o,
   output logic              frame_done_o,
   output logic              busy_o
);

   localparam int unsigned TW = K * K * DW;

   if (!k_legal(K)) begin : g_bad_k
      $error("window_buffer_nxn: K must be odd and within 3..9");
   end
   if ((COLS < K) || (ROWS < K)) begin : g_bad_dim
      $error("window_buffer_nxn: COLS and ROWS must be at least K");
   end

   logic          accept;
   logic [TW-1:0] tap_q;
   logic [TW-1:0] tap_d;

   assign accept = valid_i & ~clr_i;

`ifdef WINDOW_BUFFER_BORDER_ZERO_EN
   localparam int unsigned RW = row_cnt_w(ROWS);
   localparam int unsigned CW = col_cnt_w(COLS);
   logic [RW-1:0] row;
   logic [CW-1:0] col;
`endif

   window_buffer_nxn_ctrl #(
      .K    (K),
      .COLS (COLS),
      .ROWS (ROWS)
   ) u_ctrl (
      .clk          (clk),
      .rst          (rst),
      .clr_i        (clr_i),
      .valid_i      (valid_i),
`ifdef WINDOW_BUFFER_BORDER_ZERO_EN
      .row_o        (row),
      .col_o        (col),
`endif
      .valid_o      (valid_o),
      .frame_done_o (frame_done_o),
      .busy_o       (busy_o)
   );

   // Each tap row shifts left; the incoming column lands in the rightmost tap.
   always_comb begin
      tap_d = tap_q;
      for (int tr = 0; tr < int'(K); tr++) begin
         for (int tc = 0; tc < int'(K) - 1; tc++) begin
            tap_d[(tr*int'(K) + tc)*int'(DW) +: DW] = tap_q[(tr*int'(K) + tc + 1)*int'(DW) +: DW];
         end
         tap_d[(tr*int'(K) + int'(K) - 1)*int'(DW) +: DW] = col_i[tr*int'(DW) +: DW];
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tap_q <= '0;
      end else if (clr_i) begin
         tap_q <= '0;
      end else if (accept) begin
         tap_q <= tap_d;
      end
   end

`ifdef WINDOW_BUFFER_BORDER_ZERO_EN
   logic [TW-1:0] win_d;
   logic [TW-1:0] win_q;

   // Taps mapping above or left of the image are zeroed; row/col give the incoming pixel.
   always_comb begin
      win_d = tap_d;
      for (int tr = 0; tr < int'(K); tr++) begin
         for (int tc = 0; tc < int'(K); tc++) begin
            if ((int'(row) + tr < int'(K) - 1) || (int'(col) + tc < int'(K) - 1)) begin
               win_d[(tr*int'(K) + tc)*int'(DW) +: DW] = '0;
            end
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         win_q <= '0;
      end else if (clr_i) begin
         win_q <= '0;
      end else if (accept) begin
         win_q <= win_d;
      end
   end

   assign window_o = win_q;
`else
   assign window_o = tap_q;
`endif

endmodule

// File: tb/tb_window_buffer_nxn.sv
// Directed bench for window_buffer_nxn at K=3, 4x4 image, pixel value r*16+c.
// Expectations follow WINDOW_BUFFER_BORDER_ZERO_EN when it is defined.
module tb_window_buffer_nxn;

   localparam int unsigned K    = 3;
   localparam int unsigned DW   = 8;
   localparam int unsigned COLS = 4;
   localparam int unsigned ROWS = 4;
   localparam int unsigned WW   = K * K * DW;
   localparam int unsigned NPIX = COLS * ROWS;

`ifdef WINDOW_BUFFER_BORDER_ZERO_EN
   localparam bit BORDER  = 1'b1;
   localparam int EXP_WIN = 16;
`else
   localparam bit BORDER  = 1'b0;
   localparam int EXP_WIN = 4;
`endif

   logic            clk = 1'b0;
   logic            rst;
   logic            clr_i;
   logic            valid_i;
   logic [K*DW-1:0] col_i;
   logic [WW-1:0]   window_o;
   logic            valid_o;
   logic            frame_done_o;
   logic            busy_o;

   int n_checks = 0;
   int n_fail   = 0;

   window_buffer_nxn #(
      .K    (K),
      .DW   (DW),
      .COLS (COLS),
      .ROWS (ROWS)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .clr_i        (clr_i),
      .valid_i      (valid_i),
      .col_i        (col_i),
      .window_o     (window_o),
      .valid_o      (valid_o),
      .frame_done_o (frame_done_o),
      .busy_o       (busy_o)
   );

   always #5 clk = ~clk;

   // Line-buffer model: slice i carries image row r-(K-1)+i, 0xFF above the image.
   function automatic logic [K*DW-1:0] column(input int r, input int c);
      logic [K*DW-1:0] v;
      int lr;
      v = '0;
      for (int i = 0; i < int'(K); i++) begin
         lr = r - (int'(K) - 1) + i;
         v[i*int'(DW) +: DW] = (lr < 0) ? 8'hFF : 8'(lr * 16 + c);
      end
      return v;
   endfunction

   function automatic logic [WW-1:0] exp_win(input int r, input int c);
      logic [WW-1:0] w;
      int pr;
      int pc;
      w = '0;
      for (int tr = 0; tr < int'(K); tr++) begin
         for (int tc = 0; tc < int'(K); tc++) begin
            pr = r - (int'(K) - 1) + tr;
            pc = c - (int'(K) - 1) + tc;
            w[(tr*int'(K) + tc)*int'(DW) +: DW] = (pr < 0 || pc < 0) ? 8'h00 : 8'(pr * 16 + pc);
         end
      end
      return w;
   endfunction

   function automatic logic exp_valid(input int r, input int c);
      return BORDER || ((r >= int'(K) - 1) && (c >= int'(K) - 1));
   endfunction

   task automatic send(input int r, input int c);
      col_i   = column(r, c);
      valid_i = 1'b1;
      @(posedge clk);
      #1;
      valid_i = 1'b0;
   endtask

   // Streams pixels 0..npix-1 in raster order, optional idle gap after pixel gap_idx.
   task automatic play_frame(input int npix, input int gap_idx, input int gap_n,
                             output int nv, output int nd);
      int r;
      int c;
      logic ev;
      logic last;
      nv = 0;
      nd = 0;
      for (int i = 0; i < npix; i++) begin
         r = i / int'(COLS);
         c = i % int'(COLS);
         ev   = exp_valid(r, c);
         last = (r == int'(ROWS) - 1) && (c == int'(COLS) - 1);
         send(r, c);
         if (valid_o) nv++;
         if (frame_done_o) nd++;
         n_checks++;
         if (valid_o !== ev) begin
            n_fail++;
            $display("FAIL valid_o pix(%0d,%0d): got %b exp %b", r, c, valid_o, ev);
         end
         if (ev) begin
            n_checks++;
            if (window_o !== exp_win(r, c)) begin
               n_fail++;
               $display("FAIL window pix(%0d,%0d): got %h exp %h", r, c, window_o, exp_win(r, c));
            end
         end
         n_checks++;
         if (frame_done_o !== last) begin
            n_fail++;
            $display("FAIL frame_done pix(%0d,%0d): got %b exp %b", r, c, frame_done_o, last);
         end
         n_checks++;
         if (busy_o !== !last) begin
            n_fail++;
            $display("FAIL busy pix(%0d,%0d): got %b exp %b", r, c, busy_o, !last);
         end
         if (i == gap_idx) begin
            repeat (gap_n) begin
               @(posedge clk);
               #1;
               n_checks++;
               if (valid_o !== 1'b0 || frame_done_o !== 1'b0 || busy_o !== 1'b1) begin
                  n_fail++;
                  $display("FAIL gap flags after (%0d,%0d): got v=%b d=%b b=%b exp v=0 d=0 b=1",
                           r, c, valid_o, frame_done_o, busy_o);
               end
               if (ev) begin
                  n_checks++;
                  if (window_o !== exp_win(r, c)) begin
                     n_fail++;
                     $display("FAIL gap window hold: got %h exp %h", window_o, exp_win(r, c));
                  end
               end
            end
         end
      end
   endtask

   task automatic test_reset();
      rst     = 1'b1;
      clr_i   = 1'b0;
      valid_i = 1'b0;
      col_i   = '0;
      #12;
      n_checks++;
      if (window_o !== '0 || valid_o !== 1'b0 || frame_done_o !== 1'b0 || busy_o !== 1'b0) begin
         n_fail++;
         $display("FAIL reset outputs: got w=%h v=%b d=%b b=%b exp all 0",
                  window_o, valid_o, frame_done_o, busy_o);
      end
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;
   endtask

   task automatic test_frame();
      int nv;
      int nd;
      play_frame(int'(NPIX), -1, 0, nv, nd);
      n_checks++;
      if (nv !== EXP_WIN) begin
         n_fail++;
         $display("FAIL frame window count: got %0d exp %0d", nv, EXP_WIN);
      end
      n_checks++;
      if (nd !== 1) begin
         n_fail++;
         $display("FAIL frame done count: got %0d exp 1", nd);
      end
   endtask

   task automatic test_gap();
      int nv;
      int nd;
      play_frame(int'(NPIX), 2 * int'(COLS) + 2, 3, nv, nd);
      n_checks++;
      if (nv !== EXP_WIN || nd !== 1) begin
         n_fail++;
         $display("FAIL gap frame counts: got %0d/%0d exp %0d/1", nv, nd, EXP_WIN);
      end
   endtask

   task automatic test_back_to_back();
      int nv1;
      int nd1;
      int nv2;
      int nd2;
      play_frame(int'(NPIX), -1, 0, nv1, nd1);
      play_frame(int'(NPIX), -1, 0, nv2, nd2);
      n_checks++;
      if (nv1 + nv2 !== 2 * EXP_WIN) begin
         n_fail++;
         $display("FAIL b2b window count: got %0d exp %0d", nv1 + nv2, 2 * EXP_WIN);
      end
      n_checks++;
      if (nd1 + nd2 !== 2) begin
         n_fail++;
         $display("FAIL b2b done count: got %0d exp 2", nd1 + nd2);
      end
   endtask

   task automatic test_clear();
      int nv;
      int nd;
      play_frame(6, -1, 0, nv, nd);
      col_i   = column(1, 2);
      valid_i = 1'b1;
      clr_i   = 1'b1;
      @(posedge clk);
      #1;
      valid_i = 1'b0;
      clr_i   = 1'b0;
      n_checks++;
      if (busy_o !== 1'b0 || valid_o !== 1'b0 || frame_done_o !== 1'b0 || window_o !== '0) begin
         n_fail++;
         $display("FAIL clear: got w=%h v=%b d=%b b=%b exp all 0",
                  window_o, valid_o, frame_done_o, busy_o);
      end
      play_frame(int'(NPIX), -1, 0, nv, nd);
      n_checks++;
      if (nv !== EXP_WIN || nd !== 1) begin
         n_fail++;
         $display("FAIL restart counts: got %0d/%0d exp %0d/1", nv, nd, EXP_WIN);
      end
   endtask

   task automatic test_async_reset();
      int nv;
      int nd;
      play_frame(3 * int'(COLS) + 3, -1, 0, nv, nd);
      #3;
      rst = 1'b1;
      #1;
      n_checks++;
      if (window_o !== '0 || valid_o !== 1'b0 || frame_done_o !== 1'b0 || busy_o !== 1'b0) begin
         n_fail++;
         $display("FAIL async reset: got w=%h v=%b d=%b b=%b exp all 0",
                  window_o, valid_o, frame_done_o, busy_o);
      end
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;
      play_frame(int'(NPIX), -1, 0, nv, nd);
      n_checks++;
      if (nv !== EXP_WIN || nd !== 1) begin
         n_fail++;
         $display("FAIL post-reset counts: got %0d/%0d exp %0d/1", nv, nd, EXP_WIN);
      end
   endtask

   task automatic test_border();
      logic [WW-1:0] w01;
      int nv;
      int nd;
      w01 = '0;
      w01[7*int'(DW) +: DW] = 8'h00;
      w01[8*int'(DW) +: DW] = 8'h01;
      send(0, 0);
      send(0, 1);
      n_checks++;
      if (valid_o !== 1'b1 || window_o !== w01) begin
         n_fail++;
         $display("FAIL border pix(0,1): got v=%b w=%h exp v=1 w=%h", valid_o, window_o, w01);
      end
      clr_i = 1'b1;
      @(posedge clk);
      #1;
      clr_i = 1'b0;
      play_frame(int'(NPIX), -1, 0, nv, nd);
      n_checks++;
      if (nv !== 16) begin
         n_fail++;
         $display("FAIL border window count: got %0d exp 16", nv);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL timeout: bench did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      test_reset();
      test_frame();
      test_gap();
      test_back_to_back();
      test_clear();
      test_async_reset();
      if (BORDER) test_border();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
